// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC+4 buffer, used when a response lands while decode is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= 32'h0;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= new_instr;
      pc4   <= new_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage + IF/ID register with a single-outstanding imem handshake.
// Define MIPS_FETCH_DELAY_SLOT_EN for branch-delay-slot semantics instead of flushing.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         PCSrcD,
  input  logic [31:0]  PCBranchD,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  PCF,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCPlus4D,
  output logic         ValidD,
  output fetch_state_t fetch_state
);

`ifdef MIPS_FETCH_DELAY_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  // Handshake: imem_req/imem_addr form one valid/ready pair; once raised, the
  // request and its address hold until the cycle imem_ready is seen high.
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_d, req_pc_q, req_pc_d, redir_pc_q, redir_pc_d;
  logic         redir_pend_q, redir_pend_d, req_held_q;
  logic         accept, redirect;
  logic         buf_load, buf_clear, buf_valid;
  logic [31:0]  buf_instr, buf_pc4;
  logic         ifid_valid_d;
  logic [31:0]  ifid_instr_d, ifid_pc4_d;

  assign imem_req    = rst_n && (state_q == ISSUE) && (!StallF || req_held_q);
  assign imem_addr   = PCF;
  assign accept      = imem_req && imem_ready;
  assign redirect    = PCSrcD && !StallD;
  assign fetch_state = state_q;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .new_instr (imem_rdata),
    .new_pc4   (req_pc_q + PC_INC),
    .instr     (buf_instr),
    .pc4       (buf_pc4),
    .valid     (buf_valid)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = PCF;
    req_pc_d     = req_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    ifid_valid_d = 1'b0;
    ifid_instr_d = NOP_INSTR;
    ifid_pc4_d   = PCPlus4D;
    unique case (state_q)
      ISSUE: begin
        if (accept) begin
          req_pc_d     = PCF;
          redir_pend_d = 1'b0;
          if (redirect) begin
            pc_d    = PCBranchD;
            state_d = SLOT_EN ? WAIT : DROP;
          end else if (redir_pend_q) begin
            pc_d    = redir_pc_q;
            state_d = SLOT_EN ? WAIT : DROP;
          end else begin
            pc_d    = PCF + PC_INC;
            state_d = WAIT;
          end
        end else if (redirect) begin
          // A raised request must keep its address, so the target waits for accept.
          if (imem_req || SLOT_EN) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = PCBranchD;
          end else begin
            pc_d         = PCBranchD;
            redir_pend_d = 1'b0;
          end
        end
      end
      WAIT: begin
        if (redirect && !SLOT_EN) begin
          pc_d    = PCBranchD;
          state_d = imem_rvalid ? ISSUE : DROP;
        end else begin
          if (redirect) pc_d = PCBranchD;
          if (imem_rvalid) begin
            if (!StallD) begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = req_pc_q + PC_INC;
              state_d      = ISSUE;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (redirect && !SLOT_EN) begin
          pc_d      = PCBranchD;
          buf_clear = 1'b1;
          state_d   = ISSUE;
        end else if (!StallD) begin
          if (redirect) pc_d = PCBranchD;
          ifid_valid_d = buf_valid;
          ifid_instr_d = buf_valid ? buf_instr : NOP_INSTR;
          ifid_pc4_d   = buf_valid ? buf_pc4 : PCPlus4D;
          buf_clear    = 1'b1;
          state_d      = ISSUE;
        end
      end
      DROP: begin
        if (redirect) pc_d = PCBranchD;
        if (imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ISSUE;
      PCF          <= RESET_PC;
      req_pc_q     <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      req_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      PCF          <= pc_d;
      req_pc_q     <= req_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      req_held_q   <= imem_req && !imem_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= ifid_instr_d;
      PCPlus4D <= ifid_pc4_d;
      ValidD   <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;
  import mips_fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         StallF, StallD, PCSrcD;
  logic [31:0]  PCBranchD;
  logic         imem_req, imem_ready, imem_rvalid;
  logic [31:0]  imem_addr, imem_rdata;
  logic [31:0]  PCF, InstrD, PCPlus4D;
  logic         ValidD;
  fetch_state_t fetch_state;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model: one pending response, returned mem_cnt+1 cycles after accept
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  typedef struct {
    logic        sf, sd, ps;
    logic [31:0] tgt;
    logic        rdy;
    int          lat;
    logic        req;
    logic [31:0] addr, pcf;
    logic        v;
    logic [31:0] instr, pc4;
  } vec_t;

  vec_t vecs[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallF      (StallF),
    .StallD      (StallD),
    .PCSrcD      (PCSrcD),
    .PCBranchD   (PCBranchD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .fetch_state (fetch_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'h2400, a[15:0]};
  endfunction

  function automatic void add(input logic sf, input logic sd, input logic ps,
                              input logic [31:0] tgt, input logic rdy, input int lat,
                              input logic req, input logic [31:0] addr,
                              input logic [31:0] pcf, input logic v,
                              input logic [31:0] instr, input logic [31:0] pc4);
    vec_t t;
    t.sf = sf; t.sd = sd; t.ps = ps; t.tgt = tgt; t.rdy = rdy; t.lat = lat;
    t.req = req; t.addr = addr; t.pcf = pcf; t.v = v; t.instr = instr; t.pc4 = pc4;
    vecs.push_back(t);
  endfunction

  task automatic chk(input int idx, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    StallF = v.sf; StallD = v.sd; PCSrcD = v.ps; PCBranchD = v.tgt; imem_ready = v.rdy;
    if (mem_pend && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_addr);
      mem_pend    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (mem_pend) mem_cnt--;
    end
    #1;
    chk(idx, "imem_req", {31'd0, imem_req}, {31'd0, v.req});
    if (v.req) chk(idx, "imem_addr", imem_addr, v.addr);
    if (imem_req && imem_ready) begin
      mem_pend = 1'b1;
      mem_cnt  = v.lat - 1;
      mem_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    chk(idx, "PCF", PCF, v.pcf);
    chk(idx, "ValidD", {31'd0, ValidD}, {31'd0, v.v});
    chk(idx, "InstrD", InstrD, v.instr);
    chk(idx, "PCPlus4D", PCPlus4D, v.pc4);
  endtask

  task automatic chk_reset_values(input int idx);
    chk(idx, "rst PCF", PCF, 32'h0);
    chk(idx, "rst ValidD", {31'd0, ValidD}, 32'd0);
    chk(idx, "rst InstrD", InstrD, 32'h0);
    chk(idx, "rst PCPlus4D", PCPlus4D, 32'h0);
    chk(idx, "rst imem_req", {31'd0, imem_req}, 32'd0);
    chk(idx, "rst state", {30'd0, fetch_state}, {30'd0, ISSUE});
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; mem_pend = 1'b0;
    mem_cnt = 0; mem_addr = 32'h0;
    #1;
    chk_reset_values(-1);

`ifdef MIPS_FETCH_DELAY_SLOT_EN
    //  sf sd ps tgt           rdy lat | req addr          pcf           v  instr          pc4
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h0,         32'h4,        0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h4,        1, 32'h2400_0000, 32'h4);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h4,         32'h8,        0, 32'h0,         32'h4);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h8,        1, 32'h2400_0004, 32'h8);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h8,         32'hC,        0, 32'h0,         32'h8);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'hC,        1, 32'h2400_0008, 32'hC);
    add(0, 0, 1, 32'h40,       1, 1,   1, 32'hC,         32'h40,       0, 32'h0,         32'hC);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h40,       1, 32'h2400_000C, 32'h10);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h40,        32'h44,       0, 32'h0,         32'h10);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h44,       1, 32'h2400_0040, 32'h44);
`else
    // streaming, decode stall into HOLD, redirect with same-cycle response
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h0,         32'h4,        0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h4,        1, 32'h2400_0000, 32'h4);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h4,         32'h8,        0, 32'h0,         32'h4);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h8,        1, 32'h2400_0004, 32'h8);
    add(0, 1, 0, 32'h0,        1, 1,   1, 32'h8,         32'hC,        1, 32'h2400_0004, 32'h8);
    add(0, 1, 0, 32'h0,        1, 1,   0, 32'h0,         32'hC,        1, 32'h2400_0004, 32'h8);
    add(0, 1, 0, 32'h0,        1, 1,   0, 32'h0,         32'hC,        1, 32'h2400_0004, 32'h8);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'hC,        1, 32'h2400_0008, 32'hC);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'hC,         32'h10,       0, 32'h0,         32'hC);
    add(0, 0, 1, 32'h100,      1, 1,   0, 32'h0,         32'h100,      0, 32'h0,         32'hC);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h100,       32'h104,      0, 32'h0,         32'hC);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h104,      1, 32'h2400_0100, 32'h104);
    // unaccepted request: address holds across redirect and StallF, then drop
    add(0, 0, 0, 32'h0,        0, 1,   1, 32'h104,       32'h104,      0, 32'h0,         32'h104);
    add(0, 0, 1, 32'h200,      0, 1,   1, 32'h104,       32'h104,      0, 32'h0,         32'h104);
    add(1, 0, 0, 32'h0,        0, 1,   1, 32'h104,       32'h104,      0, 32'h0,         32'h104);
    add(0, 0, 0, 32'h0,        0, 1,   1, 32'h104,       32'h104,      0, 32'h0,         32'h104);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h104,       32'h200,      0, 32'h0,         32'h104);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h200,      0, 32'h0,         32'h104);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h200,       32'h204,      0, 32'h0,         32'h104);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h204,      1, 32'h2400_0200, 32'h204);
    // StallF before a request is raised
    add(1, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h204,      0, 32'h0,         32'h204);
    add(1, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h204,      0, 32'h0,         32'h204);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h204,       32'h208,      0, 32'h0,         32'h204);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h208,      1, 32'h2400_0204, 32'h208);
    // PCSrcD together with StallD is ignored
    add(0, 1, 1, 32'h300,      1, 1,   1, 32'h208,       32'h20C,      1, 32'h2400_0204, 32'h208);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h20C,      1, 32'h2400_0208, 32'h20C);
    // redirect in WAIT before the response, late response discarded in DROP
    add(0, 0, 0, 32'h0,        1, 2,   1, 32'h20C,       32'h210,      0, 32'h0,         32'h20C);
    add(0, 0, 1, 32'h400,      1, 1,   0, 32'h0,         32'h400,      0, 32'h0,         32'h20C);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h400,      0, 32'h0,         32'h20C);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h400,       32'h404,      0, 32'h0,         32'h20C);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h404,      1, 32'h2400_0400, 32'h404);
    // PC wrap at the top of the address space
    add(1, 0, 1, 32'hFFFF_FFFC, 1, 1,  0, 32'h0,         32'hFFFF_FFFC, 0, 32'h0,        32'h404);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'hFFFF_FFFC, 32'h0,        0, 32'h0,         32'h404);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h0,        1, 32'h2400_FFFC, 32'h0);
    // redirect out of HOLD discards the buffered instruction
    add(0, 1, 0, 32'h0,        1, 1,   1, 32'h0,         32'h4,        1, 32'h2400_FFFC, 32'h0);
    add(0, 1, 0, 32'h0,        1, 1,   0, 32'h0,         32'h4,        1, 32'h2400_FFFC, 32'h0);
    add(0, 0, 1, 32'h500,      1, 1,   0, 32'h0,         32'h500,      0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,        1, 1,   1, 32'h500,       32'h504,      0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,        1, 1,   0, 32'h0,         32'h504,      1, 32'h2400_0500, 32'h504);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // asynchronous reset mid-cycle, then a stale response right after release
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values(-2);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; StallF = 1'b1; StallD = 1'b0;
    PCSrcD = 1'b0; imem_ready = 1'b0; mem_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(-3, "stale ValidD", {31'd0, ValidD}, 32'd0);
    chk(-3, "stale InstrD", InstrD, 32'h0);
    chk(-3, "stale PCF", PCF, 32'h0);
    chk(-3, "stale state", {30'd0, fetch_state}, {30'd0, ISSUE});
    @(negedge clk);
    imem_rvalid = 1'b0; StallF = 1'b0; imem_ready = 1'b1;
    #1;
    chk(-3, "resume imem_req", {31'd0, imem_req}, 32'd1);
    chk(-3, "resume imem_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
